// File: rtl/fetch_pkg.sv
// Shared widths and the queue entry payload for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned INST_W     = 32;
   localparam int unsigned PC_W       = 32;
   localparam int unsigned PC_STEP    = 4;
   localparam int unsigned WORD_SHIFT = 2;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [PC_W-1:0]   pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush, occupancy count and same-cycle push/pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   output fetch_entry_t           head,
   output logic                   valid,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fetch_entry_t    mem [DEPTH];
   logic [AW-1:0]   head_ptr;
   logic [AW-1:0]   tail_ptr;
   logic            do_push;
   logic            do_pop;

   assign valid   = (count != '0);
   assign do_push = push && !flush;
   assign do_pop  = pop && valid && !flush;
   // Empty queue presents an all-zero entry rather than stale storage.
   assign head    = valid ? mem[head_ptr] : '0;

   always_ff @(posedge clk) begin
      if (!rst && do_push) begin
         mem[tail_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (do_push) tail_ptr <= tail_ptr + AW'(1);
         if (do_pop)  head_ptr <= head_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Upstream credit accounting guarantees a push never lands on a full queue.
   always_ff @(posedge clk) begin
      if (!rst && do_push && !do_pop) begin
         assert (count != CW'(DEPTH)) else $error("fetch_fifo overflow");
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, issues ROM reads under a credit limit and queues returned instructions.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [PC_W-1:0]        imem_addr,
   output logic                   imem_rd_en,
   input  logic [INST_W-1:0]      imem_data,
   input  logic                   redirect,
   input  logic [PC_W-1:0]        redirect_pc,
   output logic                   inst_valid,
   input  logic                   inst_ready,
   output logic [INST_W-1:0]      inst,
   output logic [PC_W-1:0]        inst_pc,
   output logic [$clog2(DEPTH):0] count
);

   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] req_pc;
   logic            inflight_q;
   logic            push;
   fetch_entry_t    push_data;
   fetch_entry_t    head;

   // Credit counts the outstanding read so a response always has a free slot.
   assign imem_rd_en = !rst && !redirect && ((32'(count) + 32'(inflight_q)) < DEPTH);
   assign imem_addr  = PC_W'(pc >> WORD_SHIFT);

   assign push      = inflight_q && !redirect && !rst;
   assign push_data = '{inst: imem_data, pc: req_pc};

   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= RESET_PC;
         req_pc     <= '0;
         inflight_q <= 1'b0;
      end else if (redirect) begin
         pc         <= redirect_pc & ~PC_W'(PC_STEP - 1);
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= imem_rd_en;
         if (imem_rd_en) begin
            pc     <= pc + PC_W'(PC_STEP);
            req_pc <= pc;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect),
      .push      (push),
      .push_data (push_data),
      .pop       (inst_ready),
      .head      (head),
      .valid     (inst_valid),
      .count     (count)
   );

   assign inst    = head.inst;
   assign inst_pc = head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table, corner sequences and random traffic vs a queue model.
module tb_fetch_queue;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] imem_addr;
   logic        imem_rd_en;
   logic [31:0] imem_data = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_bad = 0;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_addr   (imem_addr),
      .imem_rd_en  (imem_rd_en),
      .imem_data   (imem_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .count       (count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] word);
      return 32'h1000_0000 + word;
   endfunction

   // ROM answers one cycle after a request; junk otherwise so stray pushes show up.
   always @(posedge clk) imem_data <= imem_rd_en ? rom(imem_addr) : 32'hBAD0_BAD0;

   // Reference model: spec-level state with an SV queue as the buffer.
   typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
   ent_t        m_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_req_pc;
   bit          m_infl;

   function automatic bit m_issue();
      return !rst && !redirect && ((m_q.size() + int'(m_infl)) < DEPTH);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_model();
      bit v;
      v = m_q.size() > 0;
      chk("rd_en", 32'(imem_rd_en), 32'(m_issue()));
      chk("addr", imem_addr, m_pc >> 2);
      chk("valid", 32'(inst_valid), 32'(v));
      chk("inst", inst, v ? m_q[0].inst : 32'h0);
      chk("inst_pc", inst_pc, v ? m_q[0].pc : 32'h0);
      chk("count", 32'(count), 32'(m_q.size()));
   endtask

   // Advance the model across the coming edge, then the DUT; leaves time at posedge+1.
   task automatic tick();
      bit iss, pop;
      iss = m_issue();
      pop = (m_q.size() > 0) && inst_ready;
      if (rst) begin
         m_q.delete();
         m_pc   = RESET_PC;
         m_infl = 1'b0;
      end else if (redirect) begin
         m_q.delete();
         m_pc   = {redirect_pc[31:2], 2'b00};
         m_infl = 1'b0;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (m_infl) m_q.push_back('{inst: rom(m_req_pc >> 2), pc: m_req_pc});
         m_infl = iss;
         if (iss) begin
            m_req_pc = m_pc;
            m_pc     = m_pc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      #2;
      check_model();
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; redirect = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic        red;
      logic [31:0] rpc;
      logic        rd;
      logic [31:0] addr;
      logic        v;
      logic [31:0] pc;
      int          cnt;
   } vec_t;

   vec_t tbl[17];

   initial begin
      // ready held high; redirects to 0x40, 0x43 and 0xFFFF_FFFC
      tbl[0]  = '{1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         0};
      tbl[1]  = '{1'b0, 32'h0,         1'b1, 32'h1,         1'b0, 32'h0,         0};
      tbl[2]  = '{1'b0, 32'h0,         1'b1, 32'h2,         1'b1, 32'h0,         1};
      tbl[3]  = '{1'b1, 32'h40,        1'b0, 32'h3,         1'b1, 32'h4,         1};
      tbl[4]  = '{1'b0, 32'h0,         1'b1, 32'h10,        1'b0, 32'h0,         0};
      tbl[5]  = '{1'b0, 32'h0,         1'b1, 32'h11,        1'b0, 32'h0,         0};
      tbl[6]  = '{1'b0, 32'h0,         1'b1, 32'h12,        1'b1, 32'h40,        1};
      tbl[7]  = '{1'b1, 32'h43,        1'b0, 32'h13,        1'b1, 32'h44,        1};
      tbl[8]  = '{1'b0, 32'h0,         1'b1, 32'h10,        1'b0, 32'h0,         0};
      tbl[9]  = '{1'b0, 32'h0,         1'b1, 32'h11,        1'b0, 32'h0,         0};
      tbl[10] = '{1'b0, 32'h0,         1'b1, 32'h12,        1'b1, 32'h40,        1};
      tbl[11] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h13,        1'b1, 32'h44,        1};
      tbl[12] = '{1'b0, 32'h0,         1'b1, 32'h3FFF_FFFF, 1'b0, 32'h0,         0};
      tbl[13] = '{1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         0};
      tbl[14] = '{1'b0, 32'h0,         1'b1, 32'h1,         1'b1, 32'hFFFF_FFFC, 1};
      tbl[15] = '{1'b0, 32'h0,         1'b1, 32'h2,         1'b1, 32'h0,         1};
      tbl[16] = '{1'b0, 32'h0,         1'b1, 32'h3,         1'b1, 32'h4,         1};

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      m_q.delete(); m_pc = RESET_PC; m_req_pc = '0; m_infl = 1'b0;

      // Reset state while rst is held
      #2;
      chk("rst_rd_en", 32'(imem_rd_en), 32'h0);
      chk("rst_addr", imem_addr, RESET_PC >> 2);
      chk("rst_valid", 32'(inst_valid), 32'h0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      tick();
      rst = 1'b0;

      // Directed table
      inst_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         redirect    = tbl[i].red;
         redirect_pc = tbl[i].rpc;
         #2;
         chk($sformatf("tbl%0d_rd_en", i), 32'(imem_rd_en), 32'(tbl[i].rd));
         chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
         chk($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(tbl[i].v));
         chk($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].pc);
         chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
         check_model();
         tick();
      end
      redirect = 1'b0;

      // Backpressure from reset: queue fills, issue stops, then drains in order
      do_reset();
      inst_ready = 1'b0;
      repeat (7) cycle();
      #2;
      chk("full_count", 32'(count), 32'(DEPTH));
      chk("full_rd_en", 32'(imem_rd_en), 32'h0);
      chk("full_head_pc", inst_pc, 32'h0);
      inst_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) #2;
         chk($sformatf("drain%0d_valid", i), 32'(inst_valid), 32'h1);
         chk($sformatf("drain%0d_pc", i), inst_pc, 32'(4 * i));
         check_model();
         tick();
      end

      // Reset mid-flight with three queued and one outstanding
      do_reset();
      inst_ready = 1'b0;
      repeat (4) cycle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #2;
      chk("mrst_valid", 32'(inst_valid), 32'h0);
      chk("mrst_count", 32'(count), 32'h0);
      chk("mrst_inst", inst, 32'h0);
      chk("mrst_inst_pc", inst_pc, 32'h0);
      chk("mrst_addr", imem_addr, RESET_PC >> 2);
      check_model();
      tick();
      inst_ready = 1'b1;
      repeat (6) cycle();

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         inst_ready = ($urandom_range(0, 9) < 7);
         redirect   = ($urandom_range(0, 99) < 5);
         rst        = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else                           redirect_pc = $urandom;
         cycle();
      end
      rst = 1'b0; redirect = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
